// File: rtl/dither_pkg.sv
// Shared types and default geometry for the dithering pipeline (writer and traversal sides).
package dither_pkg;

  localparam int DEF_IMAGEX   = 64;
  localparam int DEF_IMAGEY   = 64;
  localparam int DEF_RGB_SIZE = 8;
  localparam int PIX_ADDR_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } writer_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x, y and the matching linear address, advanced one pixel per increment.
module raster_counter
  import dither_pkg::*;
#(
  parameter int IMAGEX = DEF_IMAGEX,
  parameter int IMAGEY = DEF_IMAGEY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_incr,
  output logic [PIX_ADDR_W-1:0] o_x,
  output logic [PIX_ADDR_W-1:0] o_y,
  output logic [PIX_ADDR_W-1:0] o_addr,
  output logic                  o_last
);

  localparam logic [PIX_ADDR_W-1:0] LAST_X    = PIX_ADDR_W'(IMAGEX - 1);
  localparam logic [PIX_ADDR_W-1:0] LAST_ADDR = PIX_ADDR_W'(IMAGEX * IMAGEY - 1);

  logic [PIX_ADDR_W-1:0] r_x;
  logic [PIX_ADDR_W-1:0] r_y;
  logic [PIX_ADDR_W-1:0] r_addr;

  // The linear address is stepped alongside x/y so addr == y*IMAGEX + x holds without a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_incr) begin
      r_addr <= r_addr + 1'b1;
      if (r_x == LAST_X) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;
  assign o_last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/dither_pixel_writer.sv
// Write-back end of the dithering pipeline: streams pixels into frame memory in row-major order.
// Optional stall statistics are enabled with the DITHER_WRITER_STATS_EN macro.
module dither_pixel_writer
  import dither_pkg::*;
#(
  parameter int IMAGEX   = DEF_IMAGEX,
  parameter int IMAGEY   = DEF_IMAGEY,
  parameter int RGB_SIZE = DEF_RGB_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RGB_SIZE-1:0]   in_pixel,
  output logic                  mem_we,
  output logic [PIX_ADDR_W-1:0] mem_addr,
  output logic [RGB_SIZE-1:0]   mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  frame_done,
  output logic [PIX_ADDR_W-1:0] x_pos,
`ifdef DITHER_WRITER_STATS_EN
  output logic [PIX_ADDR_W-1:0] y_pos,
  output logic [15:0]           stall_cycles
`else
  output logic [PIX_ADDR_W-1:0] y_pos
`endif
);

  writer_state_t         r_state;
  writer_state_t         w_next;
  logic [RGB_SIZE-1:0]   r_pixel;
  logic                  r_frame_done;
  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_last;
  logic [PIX_ADDR_W-1:0] w_addr;

  assign w_start_ok = (r_state == IDLE)   && start;
  assign w_accept   = (r_state == ACCEPT) && in_valid;
  assign w_ack      = (r_state == WRITE)  && mem_ack;

  raster_counter #(
    .IMAGEX (IMAGEX),
    .IMAGEY (IMAGEY)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_ok),
    .i_incr  (w_ack && !w_last),
    .o_x     (x_pos),
    .o_y     (y_pos),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)    w_next = ACCEPT;
      ACCEPT:  if (in_valid) w_next = WRITE;
      WRITE:   if (mem_ack)  w_next = w_last ? DONE : ACCEPT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_ack && w_last;
      if (w_accept) r_pixel <= in_pixel;
    end
  end

`ifdef DITHER_WRITER_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == WRITE) && !mem_ack && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`endif

  assign in_ready   = (r_state == ACCEPT);
  assign mem_we     = (r_state == WRITE);
  assign busy       = (r_state != IDLE);
  assign mem_addr   = w_addr;
  assign mem_wdata  = r_pixel;
  assign frame_done = r_frame_done;

endmodule

// File: doc/dither_pixel_writer.md
# dither_pixel_writer

- Write-back end of the dithering pipeline: the pixel traversal logic sweeps source pixels out, and this block puts processed pixels back.
- Accepts a stream of dithered pixels over a valid/ready handshake and writes each to frame memory in row-major order, one word per pixel.
- Tracks raster position (x, y) and pulses `frame_done` after the last pixel of an IMAGEX × IMAGEY frame is acknowledged by memory.

## Interface
- `IMAGEX`, 64, pixels per row
- `IMAGEY`, 64, rows per frame
- `IMAGE_SIZE`, IMAGEX*IMAGEY, pixels per frame (≤ 65536)
- `RGB_SIZE`, 8, pixel width in bits
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin a frame; sampled only in IDLE
- `in_valid` in 1: upstream pixel valid
- `in_ready` out 1: block can accept a pixel
- `in_pixel` in RGB_SIZE: dithered pixel value
- `mem_we` out 1: memory write request, held until acknowledged
- `mem_addr` out 16: linear write address, y*IMAGEX + x
- `mem_wdata` out RGB_SIZE: pixel being written
- `mem_ack` in 1: memory accepted the write this cycle
- `busy` out 1: high in every state except IDLE
- `frame_done` out 1: single-cycle pulse at end of frame
- `x_pos`, `y_pos` out 16 each: raster position of the next or current write

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: `in_ready`=0. On `start`, clear `addr`, x and y to 0, then go to ACCEPT.
  - ACCEPT: `in_ready`=1. On `in_valid && in_ready`, latch `in_pixel` into the holding register, then go to WRITE.
  - WRITE: `mem_we`=1, `in_ready`=0. `mem_addr` and `mem_wdata` stay stable until `mem_ack`.
    - On `mem_ack` with `addr == IMAGE_SIZE-1`: go to DONE.
    - On `mem_ack` otherwise: increment `addr`; x+1, or x=0 and y+1 when x == IMAGEX-1; go to ACCEPT.
  - DONE: `frame_done`=1 for exactly one cycle, then go to IDLE. x, y and `addr` hold their final values until the next `start`.
- `mem_ack` outside WRITE is ignored. `start` outside IDLE is ignored.
- `addr` is a 16-bit linear counter maintained alongside x/y; no multiplier. Invariant: `addr == y*IMAGEX + x` at all times.
- Reset mid-frame: state returns to IDLE, the in-flight pixel is discarded, and no write completes after reset.
- Reset values: `in_ready`, `mem_we`, `busy` and `frame_done` are 0; `mem_addr`, `mem_wdata`, `x_pos` and `y_pos` are 0.

## Timing
- `in_ready`, `mem_we` and `busy` are decoded combinationally from the registered state. All other outputs come straight from registers.
- `start` sampled at edge N: `in_ready`=1 in cycle N+1.
- Pixel accepted at edge N: `mem_we`=1 with that pixel in cycle N+1.
- `mem_ack` at edge M: `in_ready`=1 in cycle M+1, or `frame_done`=1 in cycle M+1 for the last pixel.
- Peak throughput is one pixel per 2 cycles, with `in_valid` held high and `mem_ack` in the first WRITE cycle.
- Full frame at peak throughput: `frame_done` is asserted 2*IMAGE_SIZE+1 cycles after `start` is sampled.

## Configuration
- Macro `DITHER_WRITER_STATS_EN`.
- Defined: adds output `stall_cycles` [15:0], which counts WRITE cycles with `mem_ack`=0.
  - Saturates at 16'hFFFF.
  - Cleared on an accepted `start` and by `rst`.
  - Holds its value through DONE and IDLE.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `dither_pkg`:
  - state enum `writer_state_t` (IDLE, ACCEPT, WRITE, DONE)
  - default IMAGEX/IMAGEY/RGB_SIZE constants
  - `PIX_ADDR_W` = 16
- One sub-module, `raster_counter`: x, y and linear address with clear and increment inputs, plus a `last` flag at IMAGE_SIZE-1. It is reused by the traversal side.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. All outputs go to 0 immediately, and `in_ready`=0 until `start`.
- Full 64×64 frame, `in_valid` tied high, `mem_ack` one cycle after `mem_we`:
  - exactly 4096 writes at addresses 0..4095 in order, with data matching the input sequence
  - one `frame_done` pulse, 8193 cycles after `start`
- Stalled memory, `mem_ack` delayed 3 cycles on pixel 5: `mem_we`=1, `mem_addr`=5 and `mem_wdata` stay constant, and `in_ready`=0 for all 3 stall cycles. With `DITHER_WRITER_STATS_EN` defined, `stall_cycles`=3 at frame end.
- Row wrap: the write after (x=63, y=0) has `mem_addr`=64, `x_pos`=0, `y_pos`=1. The final write has `mem_addr`=4095, x=63, y=63.
- `rst` pulsed during the write of pixel 100, then `start`: the next write goes to `mem_addr`=0 and no write to address 100 completes.
- `start` pulsed while `busy`=1: no effect on the address sequence, and no extra `frame_done` pulse.
